// File: rtl/intersection_pkg.sv
// rtl/intersection_pkg.sv - phase codes, phase type and timer width shared by the intersection controller
package intersection_pkg;

    localparam int TIMER_W = 4;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        PED_A     = 3'd2,
        EW_LEFT   = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_B     = 3'd6,
        NS_LEFT   = 3'd7
    } phase_t;

    // Timer load value for a duration in ticks; a duration of 0 behaves as 1.
    function automatic logic [TIMER_W-1:0] dur_m1(input int ticks);
        if (ticks <= 1) return '0;
        return TIMER_W'(ticks - 1);
    endfunction

endpackage

// File: rtl/intersection_fsm_if.sv
// rtl/intersection_fsm_if.sv - request inputs and phase outputs of the intersection sequencer
interface intersection_fsm_if;
    import intersection_pkg::*;

    logic               ped_req;
    logic [1:0]         left_req;
    phase_t             state_out;
    logic [TIMER_W-1:0] sec_left;
    logic               phase_start;

    modport master (
        output ped_req,
        output left_req,
        input  state_out,
        input  sec_left,
        input  phase_start
    );

    modport slave (
        input  ped_req,
        input  left_req,
        output state_out,
        output sec_left,
        output phase_start
    );

endinterface

// File: rtl/intersection_fsm_tick_gen.sv
// rtl/intersection_fsm_tick_gen.sv - free-running TICK_DIV prescaler producing a one-cycle tick
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/intersection_fsm.sv
// rtl/intersection_fsm.sv - traffic phase sequencer with per-phase timers and request latches
// INTERSECTION_PED_REQ_EN: when defined, pedestrian phases are entered only on a latched request.
module intersection_fsm
    import intersection_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 3,
    parameter int T_PED    = 5,
    parameter int T_LEFT   = 4
) (
    input  logic                clk,
    input  logic                reset,
    intersection_fsm_if.slave   bus
);

    logic               tick;
    phase_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         left_pend_q, left_pend_d;
    logic               phase_start_q, phase_start_d;
    logic               rst_seen_q;
    logic               ped_pend;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    function automatic logic [TIMER_W-1:0] load_val(input phase_t p);
        case (p)
            NS_GREEN, EW_GREEN:   load_val = dur_m1(T_GREEN);
            NS_YELLOW, EW_YELLOW: load_val = dur_m1(T_YELLOW);
            PED_A, PED_B:         load_val = dur_m1(T_PED);
            default:              load_val = dur_m1(T_LEFT);
        endcase
    endfunction

`ifdef INTERSECTION_PED_REQ_EN
    logic ped_pend_q, ped_pend_d;

    // Served at the end of the first cycle of a walk phase; a press in that cycle is absorbed.
    always_comb begin
        ped_pend_d = ped_pend_q | bus.ped_req;
        if (phase_start_q && (state_q == PED_A || state_q == PED_B)) ped_pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) ped_pend_q <= 1'b0;
        else       ped_pend_q <= ped_pend_d;
    end

    assign ped_pend = ped_pend_q;
`else
    logic unused_ped_req;
    assign unused_ped_req = bus.ped_req;
    assign ped_pend       = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        phase_start_d = rst_seen_q;
        left_pend_d   = left_pend_q | bus.left_req;
        if (phase_start_q && state_q == EW_LEFT) left_pend_d[1] = 1'b0;
        if (phase_start_q && state_q == NS_LEFT) left_pend_d[0] = 1'b0;
        if (tick) begin
            if (timer_q == '0) begin
                // Skip decisions use latched requests only, never the live inputs.
                case (state_q)
                    NS_GREEN:  state_d = NS_YELLOW;
                    NS_YELLOW: state_d = ped_pend ? PED_A : (left_pend_q[1] ? EW_LEFT : EW_GREEN);
                    PED_A:     state_d = left_pend_q[1] ? EW_LEFT : EW_GREEN;
                    EW_LEFT:   state_d = EW_GREEN;
                    EW_GREEN:  state_d = EW_YELLOW;
                    EW_YELLOW: state_d = ped_pend ? PED_B : (left_pend_q[0] ? NS_LEFT : NS_GREEN);
                    PED_B:     state_d = left_pend_q[0] ? NS_LEFT : NS_GREEN;
                    default:   state_d = NS_GREEN;
                endcase
                timer_d       = load_val(state_d);
                phase_start_d = 1'b1;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= NS_GREEN;
            timer_q       <= load_val(NS_GREEN);
            left_pend_q   <= 2'b00;
            phase_start_q <= 1'b0;
            rst_seen_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            left_pend_q   <= left_pend_d;
            phase_start_q <= phase_start_d;
            rst_seen_q    <= 1'b0;
        end
    end

    assign bus.state_out   = state_q;
    assign bus.sec_left    = timer_q;
    assign bus.phase_start = phase_start_q;

endmodule
